// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, colour codes and a small window-decode helper
// used by the sync generator and its pixel-rate divider.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int HS_START = DEF_H_DISPLAY + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
    localparam int VS_START = DEF_V_DISPLAY + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] WHITE = 3'b111;

    // Inclusive range test on a screen coordinate.
    function automatic logic in_window(input logic [COORD_W-1:0] v,
                                       input logic [COORD_W-1:0] lo,
                                       input logic [COORD_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate enable: a registered one-clk pulse every CLK_DIV system clocks.
module vga_pixel_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic p_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Divider next state; the pulse is issued the clk after the count reaches its last value.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = {CW{1'b0}};
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CW'(1);
            tick_d = 1'b0;
        end
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= {CW{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign p_tick = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters, sync decode and a one-pixel output register
// that keeps overlay colour and hsync/vsync aligned at the connector.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         rgb_in,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic [2:0]         rgb,
    output logic               frame_tick
);

    localparam int HT = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int VT = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(HT - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(VT - 1);
    localparam logic [COORD_W-1:0] X_VIS  = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] Y_VIS  = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_LO  = COORD_W'(H_DISPLAY + H_FP);
    localparam logic [COORD_W-1:0] HS_HI  = COORD_W'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_LO  = COORD_W'(V_DISPLAY + V_FP);
    localparam logic [COORD_W-1:0] VS_HI  = COORD_W'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic               tick_s;
    logic               video_on_s;
    logic               hsync_raw_s;
    logic               vsync_raw_s;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic [2:0]         rgb_q, rgb_d;
    logic               frame_q, frame_d;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .p_tick (tick_s)
    );

    assign video_on_s  = (x_q < X_VIS) && (y_q < Y_VIS);
    assign hsync_raw_s = ~in_window(x_q, HS_LO, HS_HI);
    assign vsync_raw_s = ~in_window(y_q, VS_LO, VS_HI);

    // Counter advance and output-stage capture; everything holds between pixel ticks.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        rgb_d   = rgb_q;
        frame_d = 1'b0;
        if (tick_s) begin
            if (x_q == X_LAST) begin
                x_d = {COORD_W{1'b0}};
                if (y_q == Y_LAST) begin
                    y_d = {COORD_W{1'b0}};
                end else begin
                    y_d = y_q + COORD_W'(1);
                end
            end else begin
                x_d = x_q + COORD_W'(1);
                y_d = y_q;
            end
            hsync_d = hsync_raw_s;
            vsync_d = vsync_raw_s;
            rgb_d   = video_on_s ? rgb_in : BLACK;
            frame_d = (x_q == X_LAST) && (y_q == Y_LAST);
        end else begin
            frame_d = 1'b0;
        end
    end

    // Timing and output registers; reset restarts the frame at (0,0) with sync inactive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q     <= {COORD_W{1'b0}};
            y_q     <= {COORD_W{1'b0}};
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= BLACK;
            frame_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
            frame_q <= frame_d;
        end
    end

    assign p_tick     = tick_s;
    assign pixel_x    = x_q;
    assign pixel_y    = y_q;
    assign video_on   = video_on_s;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign rgb        = rgb_q;
    assign frame_tick = frame_q;

endmodule
